// File: rtl/nrs_ls_estimator.sv
// LS channel estimator for NRS pilots: rx * conj(qpsk)/sqrt(2), rounded, into a DEPTH-entry buffer.
// Define NRS_EST_SAT_EN to saturate estimates instead of wrapping them to WIDTH bits.
module nrs_ls_estimator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter logic [15:0] SCALE = 16'd23170,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] rx_r,
    input  logic signed [WIDTH-1:0] rx_i,
    input  logic                    nrs_r,
    input  logic                    nrs_i,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic signed [WIDTH-1:0] rd_r,
    output logic signed [WIDTH-1:0] rd_i,
    output logic [AW:0]             est_count,
    output logic                    full,
    output logic                    done
);

    localparam int unsigned SW = WIDTH + 1;
`ifdef NRS_EST_SAT_EN
    localparam int unsigned PW = WIDTH + 17;
`else
    // Only the low WIDTH bits of q survive, so the top product bits are never needed.
    localparam int unsigned PW = WIDTH + 15;
`endif
    localparam int unsigned QW = PW - 15;

    logic                    s1_valid, s2_valid, s3_valid;
    logic signed [SW-1:0]    s1_r, s1_i;
    logic signed [PW-1:0]    s2_r, s2_i;
    logic        [WIDTH-1:0] s3_r, s3_i;
    logic        [AW-1:0]    wr_ptr;
    logic        [WIDTH-1:0] buf_r [DEPTH];
    logic        [WIDTH-1:0] buf_i [DEPTH];

    logic signed [SW-1:0]    ext_r, ext_i, sgn_rr, sgn_ri, sgn_ii, sgn_ir, sum_r, sum_i;
    logic signed [PW-1:0]    prod_r, prod_i;
    logic        [PW-1:0]    rnd_r, rnd_i;
    logic        [QW-1:0]    q_r, q_i;
    logic        [AW+1:0]    occupancy;
    logic                    accept, commit;

    function automatic logic [WIDTH-1:0] reduce(input logic [QW-1:0] q);
`ifdef NRS_EST_SAT_EN
        if (&q[QW-1:WIDTH-1] || ~|q[QW-1:WIDTH-1]) begin
            return q[WIDTH-1:0];
        end
        return q[QW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
        return q;
`endif
    endfunction

    always_comb begin
        ext_r  = {rx_r[WIDTH-1], rx_r};
        ext_i  = {rx_i[WIDTH-1], rx_i};
        sgn_rr = nrs_r ? -ext_r : ext_r;
        sgn_ri = nrs_r ? -ext_i : ext_i;
        sgn_ii = nrs_i ? -ext_i : ext_i;
        sgn_ir = nrs_i ? -ext_r : ext_r;
        sum_r  = sgn_rr + sgn_ii;
        sum_i  = sgn_ri - sgn_ir;
        prod_r = PW'(s1_r) * PW'($signed({1'b0, SCALE}));
        prod_i = PW'(s1_i) * PW'($signed({1'b0, SCALE}));
        rnd_r  = s2_r + PW'(16384);
        rnd_i  = s2_i + PW'(16384);
        q_r    = rnd_r[PW-1:15];
        q_i    = rnd_i[PW-1:15];
    end

    always_comb begin
        occupancy = {1'b0, est_count} + (AW+2)'(s1_valid) + (AW+2)'(s2_valid)
                  + (AW+2)'(s3_valid);
        full      = (occupancy == (AW+2)'(DEPTH));
        in_ready  = !full && !clear;
        accept    = in_valid && in_ready;
        commit    = s3_valid && !clear;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            s1_r      <= '0;
            s1_i      <= '0;
            s2_r      <= '0;
            s2_i      <= '0;
            s3_r      <= '0;
            s3_i      <= '0;
            wr_ptr    <= '0;
            est_count <= '0;
            done      <= 1'b0;
        end else begin
            s1_r <= sum_r;
            s1_i <= sum_i;
            s2_r <= prod_r;
            s2_i <= prod_i;
            s3_r <= reduce(q_r);
            s3_i <= reduce(q_i);
            if (clear) begin
                s1_valid  <= 1'b0;
                s2_valid  <= 1'b0;
                s3_valid  <= 1'b0;
                wr_ptr    <= '0;
                est_count <= '0;
                done      <= 1'b0;
            end else begin
                s1_valid <= accept;
                s2_valid <= s1_valid;
                s3_valid <= s2_valid;
                done     <= s3_valid && (est_count == (AW+1)'(DEPTH - 1));
                if (s3_valid) begin
                    wr_ptr    <= wr_ptr + AW'(1);
                    est_count <= est_count + (AW+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                buf_r[k] <= '0;
                buf_i[k] <= '0;
            end
        end else if (commit) begin
            buf_r[wr_ptr] <= s3_r;
            buf_i[wr_ptr] <= s3_i;
        end
    end

    // Same-cycle read of the address being written returns the old content.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_r <= '0;
            rd_i <= '0;
        end else if (rd_en) begin
            rd_r <= $signed(buf_r[rd_addr]);
            rd_i <= $signed(buf_i[rd_addr]);
        end
    end

endmodule

// File: tb/tb_nrs_ls_estimator.sv
// Scoreboard bench for nrs_ls_estimator; honours NRS_EST_SAT_EN in its reference model.
module tb_nrs_ls_estimator;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0, rst = 1'b0, clear = 1'b0, in_valid = 1'b0;
    logic nrs_r = 1'b0, nrs_i = 1'b0, rd_en = 1'b0;
    logic in_ready, full, done;
    logic signed [WIDTH-1:0] rx_r = '0, rx_i = '0;
    logic signed [WIDTH-1:0] rd_r, rd_i;
    logic [AW-1:0] rd_addr = '0;
    logic [AW:0]   est_count;

    typedef struct {
        int r;
        int i;
    } exp_t;

    exp_t rd_q[$];
    exp_t head;
    int   checks = 0, errors = 0;
    int   mem_r[DEPTH], mem_i[DEPTH];
    int   mptr = 0, done_cnt = 0;
    logic rd_fire;

    nrs_ls_estimator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .rx_r(rx_r), .rx_i(rx_i), .nrs_r(nrs_r), .nrs_i(nrs_i), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_r(rd_r), .rd_i(rd_i), .est_count(est_count),
        .full(full), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int est_model(input int r, input int i, input bit nr, input bit ni,
                                     input bit imag);
        longint sr, si, s, p, q;
        logic [16:0] w;
        logic signed [16:0] ws;
        logic [15:0] t;
        sr = nr ? -1 : 1;
        si = ni ? -1 : 1;
        s  = imag ? (sr * i - si * r) : (sr * r + si * i);
        w  = s[16:0];
        ws = w;
        p  = longint'(ws) * 23170;
        q  = (p + 16384) >>> 15;
`ifdef NRS_EST_SAT_EN
        if (q > 32767) return 32767;
        if (q < -32768) return -32768;
        return int'(q);
`else
        t = q[15:0];
        return int'($signed(t));
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) rd_fire <= 1'b0;
        else      rd_fire <= rd_en;
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (rd_fire) begin
            check("sb_pending", rd_q.size() != 0, 1);
            if (rd_q.size() != 0) begin
                head = rd_q.pop_front();
                check("rd_r", rd_r, head.r);
                check("rd_i", rd_i, head.i);
            end
        end
    end

    task automatic drive(input bit v, input int r, input int i, input bit nr, input bit ni,
                         input bit clr, output bit acc);
        @(negedge clk);
        in_valid = v;
        rx_r     = 16'(r);
        rx_i     = 16'(i);
        nrs_r    = nr;
        nrs_i    = ni;
        clear    = clr;
        rd_en    = 1'b0;
        #1 acc = v && (in_ready === 1'b1);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic store(input int r, input int i, input bit nr, input bit ni);
        mem_r[mptr] = est_model(r, i, nr, ni, 1'b0);
        mem_i[mptr] = est_model(r, i, nr, ni, 1'b1);
        mptr = (mptr + 1) % DEPTH;
    endtask

    task automatic rd(input int addr, input int er, input int ei);
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        rd_en    = 1'b1;
        rd_addr  = 3'(addr);
        rd_q.push_back('{er, ei});
    endtask

    task automatic rand_sample(output int r, output int i, output bit nr, output bit ni);
        r  = int'($urandom_range(65535)) - 32768;
        i  = int'($urandom_range(65535)) - 32768;
        nr = 1'($urandom_range(1));
        ni = 1'($urandom_range(1));
    endtask

    int  d_r[5]  = '{1000, 1000, 1000, 32767, -32768};
    int  d_i[5]  = '{2000, 2000, 2000, 32767, -32768};
    bit  d_nr[5] = '{0, 1, 1, 0, 0};
    bit  d_ni[5] = '{0, 0, 1, 0, 0};
    int  e_r[5]  = '{2121, 707, -2121,
`ifdef NRS_EST_SAT_EN
                     32767, -32768};
`else
                     -19197, 19196};
`endif
    int  e_i[5]  = '{707, -2121, -707, 0, 0};

    initial begin
        bit acc, prev8;
        int r, i, nacc;
        bit nr, ni;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_full", full, 0);
        check("rst_done", done, 0);
        check("rst_est_count", est_count, 0);
        check("rst_rd_r", rd_r, 0);
        check("rst_rd_i", rd_i, 0);
        rst = 1'b1;

        // Directed products; the first one also checks commit latency.
        drive(1'b1, d_r[0], d_i[0], d_nr[0], d_ni[0], 1'b0, acc);
        check("acc_d0", acc, 1);
        store(d_r[0], d_i[0], d_nr[0], d_ni[0]);
        for (int k = 1; k <= 4; k++) begin
            idle(1);
            check("latency_count", est_count, (k == 4) ? 1 : 0);
        end
        for (int n = 1; n < 5; n++) begin
            drive(1'b1, d_r[n], d_i[n], d_nr[n], d_ni[n], 1'b0, acc);
            check("acc_dir", acc, 1);
            store(d_r[n], d_i[n], d_nr[n], d_ni[n]);
        end
        idle(4);
        check("dir_count", est_count, 5);
        for (int n = 0; n < 5; n++) rd(n, e_r[n], e_i[n]);
        idle(1);

        // Fill with in_valid held high for 12 cycles.
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc);
        idle(1);
        check("clr_count", est_count, 0);
        check("clr_full", full, 0);
        check("clr_ready", in_ready, 1);
        mptr = 0;
        done_cnt = 0;
        nacc = 0;
        prev8 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            rand_sample(r, i, nr, ni);
            drive(1'b1, r, i, nr, ni, 1'b0, acc);
            if (prev8) check("ready_after_full", in_ready, 0);
            prev8 = 1'b0;
            if (acc) begin
                store(r, i, nr, ni);
                nacc++;
                if (nacc == DEPTH) prev8 = 1'b1;
            end
        end
        idle(4);
        check("fill_accepts", nacc, DEPTH);
        check("fill_count", est_count, DEPTH);
        check("fill_full", full, 1);
        check("fill_ready", in_ready, 0);
        check("fill_done_pulses", done_cnt, 1);
        for (int n = 0; n < DEPTH; n++) rd(n, mem_r[n], mem_i[n]);
        idle(1);

        // Clear while two samples are still in flight.
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc);
        idle(1);
        check("clr2_count", est_count, 0);
        done_cnt = 0;
        mptr = 0;
        for (int n = 0; n < 3; n++) begin
            rand_sample(r, i, nr, ni);
            drive(1'b1, r, i, nr, ni, 1'b0, acc);
            check("acc_flight", acc, 1);
            if (n == 0) store(r, i, nr, ni);
        end
        idle(1);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, acc);
        check("flight_count_pre", est_count, 1);
        idle(1);
        check("flight_count_post", est_count, 0);
        check("flight_full", full, 0);
        idle(5);
        check("flight_no_done", done_cnt, 0);
        check("flight_count_end", est_count, 0);
        mptr = 0;
        drive(1'b1, 1000, 2000, 1'b0, 1'b0, 1'b0, acc);
        check("acc_after_clr", acc, 1);
        store(1000, 2000, 1'b0, 1'b0);
        idle(4);
        check("after_clr_count", est_count, 1);
        rd(0, 2121, 707);
        rd(1, mem_r[1], mem_i[1]);
        rd(2, mem_r[2], mem_i[2]);
        idle(1);

        // Async reset with samples in flight.
        for (int n = 0; n < 5; n++) begin
            rand_sample(r, i, nr, ni);
            drive(1'b1, r, i, nr, ni, 1'b0, acc);
        end
        idle(2);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_full", full, 0);
        check("arst_done", done, 0);
        check("arst_est_count", est_count, 0);
        check("arst_rd_r", rd_r, 0);
        check("arst_rd_i", rd_i, 0);
        @(negedge clk);
        rst = 1'b1;
        rd(0, 0, 0);
        rd(3, 0, 0);
        idle(4);
        check("arst_count_after", est_count, 0);
        check("sb_drained", rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nrs_ls_estimator.md
# nrs_ls_estimator

Pipelined least-squares channel estimator for NRS pilot resource elements. Each accepted pilot sample is multiplied by the conjugate of its QPSK NRS symbol (±1±j)/√2, rounded, and written into a DEPTH-entry estimate buffer. It sits between the RE demapper and the frequency/time interpolator. It generalises the single-slot estimator to parametric width and depth, adds a valid/ready input handshake, full/done/clear control, rounding, and optional saturation.

## Interface
- WIDTH, 16: signed I/Q sample width and signed estimate width.
- DEPTH, 8: number of estimate buffer entries; must be a power of 2, ≥2.
- SCALE, 16'd23170: unsigned Q0.15 value of 1/√2.
- AW, $clog2(DEPTH): buffer address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: empties pipeline and buffer state.
- in_valid  in  1  pilot sample valid.
- in_ready  out  1  estimator can accept a sample this cycle.
- rx_r, rx_i  in  WIDTH  signed received pilot, real and imaginary parts.
- nrs_r, nrs_i  in  1  NRS sign bits: 0 means +1/√2, 1 means −1/√2.
- rd_en  in  1  buffer read request.
- rd_addr  in  AW  buffer read address.
- rd_r, rd_i  out  WIDTH  registered read data.
- est_count  out  AW+1  entries committed to the buffer.
- full  out  1  est_count plus in-flight samples equals DEPTH.
- done  out  1  one-cycle pulse when the DEPTH-th entry is committed.

## Operation
- A sample is accepted when in_valid && in_ready. in_ready = !full && !clear.
- Arithmetic: sr = nrs_r ? −1 : +1 and si = nrs_i ? −1 : +1.
  - sum_r = sr·rx_r + si·rx_i, and sum_i = sr·rx_i − si·rx_r. Both are WIDTH+1 bit signed; no multiplier is used for the signs.
  - p = sum·SCALE, signed WIDTH+17 bits.
  - q = (p + 2^14) >>> 15. This is round-half-up with an arithmetic shift, giving WIDTH+2 bits.
  - q is reduced to WIDTH bits according to the Configuration section.
- Pipeline stages:
  - S1 registers the sign-selected sums.
  - S2 registers the products.
  - S3 rounds, reduces, and writes buffer[wr_ptr].
  - After the write, wr_ptr is incremented and est_count is incremented.
- Write order is strictly sequential from address 0. wr_ptr wraps to 0 modulo DEPTH, but a wrap only occurs after clear because full blocks further input.
- full counts in-flight samples. Samples already accepted are always committed, so there is no overflow.
- Reads:
  - A read with rd_en=1 returns buffer[rd_addr] on rd_r/rd_i the next cycle.
  - With rd_en=0, rd_r/rd_i hold their previous values.
  - A read of the address being written in the same cycle returns the old content.
- clear:
  - Kills S1–S3 valid bits and sets wr_ptr, est_count and the in-flight count to 0.
  - Deasserts full and suppresses done.
  - Buffer contents and rd_r/rd_i are not cleared.
  - clear has priority over acceptance and over a same-cycle S3 commit; that commit is dropped.
- done pulses in the cycle after the commit that makes est_count = DEPTH. est_count then holds at DEPTH until clear.

## Timing
- Input-to-buffer latency: a sample accepted at edge N is committed at edge N+3. est_count reflects it after edge N+3, and done is high during the cycle after edge N+3.
- Throughput is one sample per cycle until full.
- The in_ready path is combinational from clear and registered state only, not from in_valid.
- Read latency is 1 cycle.
- Reset values:
  - in_ready = 1, full = 0, done = 0, est_count = 0.
  - rd_r = rd_i = 0.
  - All buffer entries and pipeline registers are 0.
- Reset asserted mid-operation discards in-flight samples immediately and asynchronously.
- Boundary case: with DEPTH−1 committed or in flight, accepting one more sample raises full on the next cycle. An in_valid held high in that next cycle is not accepted.

## Configuration
- NRS_EST_SAT_EN
  - Defined: q is saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Undefined: q is truncated to its low WIDTH bits (two's-complement wrap), and the saturation logic is not synthesised.

## Test plan
- Basic product: rx=(1000,2000) with nrs=(0,0) → entry 0 = (2121, 707), committed 3 cycles after acceptance.
- Negative rounding: rx=(1000,2000) with nrs=(1,0) → entry = (707, −2121). With nrs=(1,1) → entry = (−2121, −707).
- Saturation:
  - rx=(32767,32767) with nrs=(0,0) → (32767, 0) with the macro, (−19197, 0) without.
  - rx=(−32768,−32768) with nrs=(0,0) → (−32768, 0) with the macro, (19196, 0) without.
- Fill and backpressure: with DEPTH=8, hold in_valid high for 12 cycles →
  - exactly 8 samples are accepted; in_ready drops after the 8th acceptance;
  - done pulses once; est_count = 8.
  - Read back addresses 0–7 with 1-cycle latency and check they are in input order.
- Clear during flight: accept 3 samples, then assert clear one cycle after the last acceptance →
  - est_count = 1 before clear takes effect, then 0;
  - no done pulse; the next sample is written to address 0.
- Async reset mid-fill: assert rst low between clock edges → all outputs are at reset values immediately, and a read of address 0 after reset returns 0.
